// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit RV32I integer register file.
// Two combinational source-operand read ports (rs1/R1, rs2/R2), one
// synchronous write port (rd/wd/writeEnable) and a combinational debug
// read port (view/out). Register x0 reads as zero on every port.
// Writes land on the rising edge; there is no write-through bypass, so a
// read of the register being written shows the old value until the edge.

module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] view,
    output logic [DATA_W-1:0] out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] x [DEPTH];
    logic              wr_hit;

    // A write only counts when it targets a real register (x0 is read-only).
    assign wr_hit = writeEnable && (rd != '0);

    // Storage update: reset clears every entry and wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                x[i] <= '0;
            end
        end else if (wr_hit) begin
            x[rd] <= wd;
        end
    end

    // Combinational read ports; index 0 is forced to zero so x0 never
    // depends on array contents, even before the first reset edge.
    always_comb begin
        R1  = (rs1  == '0) ? '0 : x[rs1];
        R2  = (rs2  == '0) ? '0 : x[rs2];
        out = (view == '0) ? '0 : x[view];
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: table-driven vectors, hand-written corner sequences and a
// randomized run checked against an array-based reference model.

module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [31:0] R1, R2, out, wd;
    logic [4:0]  rs1, rs2, rd, view;
    logic        writeEnable;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .R1(R1), .R2(R2), .wd(wd),
        .rs1(rs1), .rs2(rs2), .rd(rd), .writeEnable(writeEnable),
        .view(view), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the register file should hold after each edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (writeEnable && rd != 5'd0) begin
            model[rd] = wd;
        end
    end

    function automatic logic [31:0] ref_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : model[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " R1"}, R1, ref_rd(rs1));
        check({tag, " R2"}, R2, ref_rd(rs2));
        check({tag, " out"}, out, ref_rd(view));
    endtask

    // Advance one edge; inputs are driven 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] d,
                         input logic [31:0] w, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] v);
        rst = r; writeEnable = we; rd = d; wd = w; rs1 = a; rs2 = b; view = v;
    endtask

    typedef struct {
        logic        r;
        logic        we;
        logic [4:0]  d;
        logic [31:0] w;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  v;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] eo;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Each row: inputs for one edge, then expected reads just after it.
        vecs[0] = '{1'b1, 1'b1, 5'd3,  32'd7,        5'd3,  5'd0,  5'd3,  32'h0,        32'h0,   32'h0};
        vecs[1] = '{1'b0, 1'b1, 5'd1,  32'd100,      5'd1,  5'd2,  5'd1,  32'd100,      32'h0,   32'd100};
        vecs[2] = '{1'b0, 1'b1, 5'd2,  32'd200,      5'd1,  5'd2,  5'd2,  32'd100,      32'd200, 32'd200};
        vecs[3] = '{1'b0, 1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,   32'h0};
        vecs[4] = '{1'b0, 1'b0, 5'd7,  32'h55,       5'd7,  5'd1,  5'd7,  32'h0,        32'd100, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd2,  5'd31, 32'hFFFFFFFF, 32'd200, 32'hFFFFFFFF};
        vecs[6] = '{1'b1, 1'b1, 5'd3,  32'd7,        5'd1,  5'd31, 5'd3,  32'h0,        32'h0,   32'h0};
        vecs[7] = '{1'b0, 1'b1, 5'd3,  32'd9,        5'd3,  5'd1,  5'd3,  32'd9,        32'h0,   32'd9};

        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Reset held for 10 edges, then a full sweep of the debug port.
        repeat (10) cyc();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            view = 5'(i);
            #1;
            check($sformatf("reset sweep x%0d", i), out, 32'h0);
        end
        rs1 = 5'd17; rs2 = 5'd30; #1;
        check("reset R1", R1, 32'h0);
        check("reset R2", R2, 32'h0);
        cyc();

        // Table-driven vectors.
        for (int k = 0; k < 8; k++) begin
            drive(vecs[k].r, vecs[k].we, vecs[k].d, vecs[k].w, vecs[k].a, vecs[k].b, vecs[k].v);
            cyc();
            check($sformatf("vec%0d R1", k), R1, vecs[k].e1);
            check($sformatf("vec%0d R2", k), R2, vecs[k].e2);
            check($sformatf("vec%0d out", k), out, vecs[k].eo);
        end

        // Basic write held 10 edges (idempotent), then a second register.
        drive(1'b0, 1'b1, 5'd1, 32'd100, 5'd0, 5'd0, 5'd1);
        repeat (10) cyc();
        writeEnable = 1'b0; #1;
        check("basic x1", out, 32'd100);
        drive(1'b0, 1'b1, 5'd2, 32'd200, 5'd0, 5'd0, 5'd2);
        cyc();
        writeEnable = 1'b0; #1;
        check("basic x2", out, 32'd200);
        view = 5'd1; #1;
        check("basic x1 kept", out, 32'd100);

        // Changing wd with writeEnable held: each edge captures the current value.
        drive(1'b0, 1'b1, 5'd4, 32'hA1, 5'd4, 5'd0, 5'd4);
        cyc();
        wd = 32'hA2;
        cyc();
        check("stream x4", R1, 32'hA2);

        // Dual read and no write-through bypass.
        drive(1'b0, 1'b1, 5'd5, 32'h11, 5'd5, 5'd6, 5'd0);
        cyc();
        drive(1'b0, 1'b1, 5'd6, 32'h22, 5'd5, 5'd6, 5'd0);
        cyc();
        writeEnable = 1'b0; #1;
        check("dual R1", R1, 32'h11);
        check("dual R2", R2, 32'h22);
        writeEnable = 1'b1; rd = 5'd5; wd = 32'h33; #1;
        check("bypass before edge", R1, 32'h11);
        cyc();
        writeEnable = 1'b0;
        check("bypass after edge", R1, 32'h33);

        // Write-enable gating over several edges.
        drive(1'b0, 1'b0, 5'd7, 32'h55, 5'd7, 5'd0, 5'd7);
        repeat (4) cyc();
        check("gated x7", out, 32'h0);

        // Reset priority mid-operation, then writes resume.
        drive(1'b1, 1'b1, 5'd3, 32'd7, 5'd1, 5'd3, 5'd3);
        cyc();
        check("rstpri x1", R1, 32'h0);
        check("rstpri x3", R2, 32'h0);
        drive(1'b0, 1'b1, 5'd3, 32'd9, 5'd0, 5'd0, 5'd3);
        cyc();
        writeEnable = 1'b0; #1;
        check("resume x3", out, 32'd9);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom),
                  $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
            #1;
            check_model("rand pre");
            cyc();
            check_model("rand post");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
